// File: rtl/maluma_pkg.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module      : maluma_pkg
// Description : Shared definitions for the maluma floating-point ALU.
//               Holds the opcode encodings, flag bit positions, format
//               constants, special-value magnitudes and the FSM state type.
//               It also provides the operand unpack, leading-zero count and
//               special-pack helper functions.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
package maluma_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;

   localparam int FLAG_NX = 4;   // inexact
   localparam int FLAG_NV = 3;   // invalid
   localparam int FLAG_DZ = 2;   // divide-by-zero
   localparam int FLAG_OF = 1;   // overflow
   localparam int FLAG_UF = 0;   // underflow

   localparam int SP_EXP_W = 8;
   localparam int SP_MAN_W = 23;
   localparam int HP_EXP_W = 5;
   localparam int HP_MAN_W = 10;
   localparam logic signed [9:0] SP_BIAS = 10'sd127;
   localparam logic signed [9:0] HP_BIAS = 10'sd15;

   // Magnitudes (sign excluded) of the special encodings.
   localparam logic [30:0] SP_INF_MAG  = 31'h7F800000;
   localparam logic [30:0] SP_MAX_MAG  = 31'h7F7FFFFF;
   localparam logic [30:0] SP_QNAN_MAG = 31'h7FC00000;
   localparam logic [14:0] HP_INF_MAG  = 15'h7C00;
   localparam logic [14:0] HP_MAX_MAG  = 15'h7BFF;
   localparam logic [14:0] HP_QNAN_MAG = 15'h7E00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Unpacked operand: sig carries the hidden bit at [23]; half-precision
   // fractions are left-aligned so every path works on 24-bit significands.
   typedef struct packed {
      logic              sign;
      logic [7:0]        ebits;
      logic signed [9:0] exp;
      logic [23:0]       sig;
      logic              zero;
      logic              inf;
      logic              nan;
   } fp_t;

   function automatic fp_t unpack(input logic [31:0] x, input logic single);
      fp_t        u;
      logic [22:0] f;
      logic [7:0]  emax;
      if (single) begin
         u.sign  = x[31];
         u.ebits = x[30:23];
         f       = x[22:0];
         emax    = 8'hFF;
      end else begin
         u.sign  = x[15];
         u.ebits = {3'b000, x[14:10]};
         f       = {x[9:0], 13'b0};
         emax    = 8'h1F;
      end
      u.exp  = $signed({2'b00, u.ebits}) - (single ? SP_BIAS : HP_BIAS);
      // Subnormals fold into zero: a zero exponent field means zero.
      u.zero = (u.ebits == 8'd0);
      u.inf  = (u.ebits == emax) && (f == 23'd0);
      u.nan  = (u.ebits == emax) && (f != 23'd0);
      u.sig  = u.zero ? 24'd0 : {1'b1, f};
      return u;
   endfunction

   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] n;
      n = 5'd27;
      for (int i = 0; i < 27; i++) begin
         if (v[i]) n = 5'(26 - i);
      end
      return n;
   endfunction

   function automatic logic [31:0] pack_special(input logic single, input logic sign,
                                                input logic [30:0] sp_mag,
                                                input logic [14:0] hp_mag);
      return single ? {sign, sp_mag} : {16'h0000, sign, hp_mag};
   endfunction

endpackage
`default_nettype wire

// File: rtl/maluma_round_pack.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module      : maluma_round_pack
// Description : Rounds a normalised significand and packs it into binary32 or
//               binary16, handling overflow and flush-to-zero underflow.
// Ports       : sign, exp (unbiased), sig[26] hidden bit / lower bits
//               fraction+G/R/S, single (1=binary32), rtz (1=truncate);
//               result, inexact, overflow, underflow.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
module maluma_round_pack
   import maluma_pkg::*;
(
   input  logic              sign,
   input  logic signed [9:0] exp,
   input  logic [26:0]       sig,
   input  logic              single,
   input  logic              rtz,
   output logic [31:0]       result,
   output logic              inexact,
   output logic              overflow,
   output logic              underflow
);

   logic [24:0]       keep;
   logic [24:0]       rnd;
   logic              guard;
   logic              rest;
   logic              lsb;
   logic              carry;
   logic signed [9:0] bexp;
   logic              unused_hidden;

   always_comb begin
      // Half precision keeps only the top 11 bits; everything below the
      // guard folds into sticky.
      if (single) begin
         keep  = {1'b0, sig[26:3]};
         guard = sig[2];
         rest  = |sig[1:0];
         lsb   = sig[3];
      end else begin
         keep  = {14'b0, sig[26:16]};
         guard = sig[15];
         rest  = |sig[14:0];
         lsb   = sig[16];
      end
      rnd   = keep + {24'b0, (~rtz & guard & (rest | lsb))};
      // Carry out of the significand means 1.111.. rounded to 10.000..
      carry = single ? rnd[24] : rnd[11];
      bexp  = exp + (single ? SP_BIAS : HP_BIAS) + $signed({9'b0, carry});

      result    = single ? {sign, bexp[7:0], rnd[22:0]}
                         : {16'h0000, sign, bexp[4:0], rnd[9:0]};
      inexact   = guard | rest;
      overflow  = 1'b0;
      underflow = 1'b0;
      if (bexp >= (single ? 10'sd255 : 10'sd31)) begin
         overflow = 1'b1;
         inexact  = 1'b1;
         result   = rtz ? pack_special(single, sign, SP_MAX_MAG, HP_MAX_MAG)
                        : pack_special(single, sign, SP_INF_MAG, HP_INF_MAG);
      end else if (bexp < 10'sd1) begin
         underflow = 1'b1;
         inexact   = 1'b1;
         result    = pack_special(single, sign, 31'd0, 15'd0);
      end
   end

   assign unused_hidden = rnd[23];

endmodule
`default_nettype wire

// File: rtl/maluma_alu.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module      : maluma_alu
// Description : Multi-cycle IEEE-754 add/sub/mul/div unit, binary32 or
//               binary16 per operation, start/valid handshake.
// Ports       : clk, rst (async, active high), start, op_a, op_b, op_code,
//               mode_fp (1=single), round_mode (1=RTZ); result, valid_out,
//               flags {inexact, invalid, div-by-zero, overflow, underflow}.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
module maluma_alu
   import maluma_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic [2:0]  op_code,
   input  logic        mode_fp,
   input  logic        round_mode,
   output logic [31:0] result,
   output logic        valid_out,
   output logic [4:0]  flags
);

   state_t      state, state_nxt;
   logic        load;
   logic [31:0] a_q, b_q;
   logic [2:0]  code_q;
   logic        single_q, rtz_q;
   logic [31:0] calc_res, res_c;
   logic [4:0]  calc_flags, flg_c;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         ST_IDLE: if (start) begin
            state_nxt = ST_EXEC;
            load      = 1'b1;
         end
         ST_EXEC: state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q        <= '0;
         b_q        <= '0;
         code_q     <= '0;
         single_q   <= 1'b0;
         rtz_q      <= 1'b0;
         calc_res   <= '0;
         calc_flags <= '0;
         result     <= '0;
         flags      <= '0;
         valid_out  <= 1'b0;
      end else begin
         if (load) begin
            a_q       <= op_a;
            b_q       <= op_b;
            code_q    <= op_code;
            single_q  <= mode_fp;
            rtz_q     <= round_mode;
            valid_out <= 1'b0;
         end
         if (state == ST_EXEC) begin
            calc_res   <= res_c;
            calc_flags <= flg_c;
         end
         if (state == ST_DONE) begin
            result    <= calc_res;
            flags     <= calc_flags;
            valid_out <= 1'b1;
         end
      end
   end

   // ---------------- datapath ----------------
   fp_t               ua, ub;
   logic              sb_eff, swap, lg_s, sm_s;
   logic [7:0]        lg_e, sm_e, ediff;
   logic [23:0]       lg_sig, sm_sig;
   logic signed [9:0] lg_exp;
   logic [5:0]        shamt;
   logic [53:0]       shifted;
   logic [26:0]       aligned;
   logic [27:0]       sum;
   logic [4:0]        lz;
   logic              add_zero;
   logic [26:0]       add_norm, mul_norm, div_norm;
   logic signed [9:0] add_exp, mul_exp, div_exp;
   logic [47:0]       prod;
   logic [50:0]       dividend;
   logic [23:0]       divisor, rem;
   logic [27:0]       quo;

   always_comb begin
      ua     = unpack(a_q, single_q);
      ub     = unpack(b_q, single_q);
      sb_eff = ub.sign ^ (code_q == OP_SUB);

      // Add/sub: order by magnitude so the difference is never negative.
      swap    = {ub.ebits, ub.sig} > {ua.ebits, ua.sig};
      lg_e    = swap ? ub.ebits : ua.ebits;
      sm_e    = swap ? ua.ebits : ub.ebits;
      lg_sig  = swap ? ub.sig   : ua.sig;
      sm_sig  = swap ? ua.sig   : ub.sig;
      lg_exp  = swap ? ub.exp   : ua.exp;
      lg_s    = swap ? sb_eff   : ua.sign;
      sm_s    = swap ? ua.sign  : sb_eff;
      ediff   = lg_e - sm_e;
      // 27 positions already push every smaller-operand bit into sticky.
      shamt   = (ediff > 8'd27) ? 6'd27 : ediff[5:0];
      shifted = {sm_sig, 30'b0} >> shamt;
      aligned = shifted[53:27] | {26'b0, |shifted[26:0]};
      sum     = (lg_s == sm_s) ? ({1'b0, lg_sig, 3'b0} + {1'b0, aligned})
                               : ({1'b0, lg_sig, 3'b0} - {1'b0, aligned});
      add_zero = (sum == 28'd0);
      lz       = lzc27(sum[26:0]);
      if (sum[27]) begin
         add_norm = sum[27:1] | {26'b0, sum[0]};
         add_exp  = lg_exp + 10'sd1;
      end else begin
         add_norm = sum[26:0] << lz;
         add_exp  = lg_exp - $signed({5'b0, lz});
      end

      // Mul: product of two [1,2) significands lies in [1,4).
      prod     = {24'b0, ua.sig} * {24'b0, ub.sig};
      mul_exp  = ua.exp + ub.exp + $signed({9'b0, prod[47]});
      mul_norm = prod[47] ? (prod[47:21] | {26'b0, |prod[20:0]})
                          : (prod[46:20] | {26'b0, |prod[19:0]});

      // Div: quotient of [1,2) significands lies in (0.5,2); 28 quotient
      // bits leave G/R plus the remainder as sticky.
      dividend = {ua.sig, 27'b0};
      divisor  = ub.zero ? 24'd1 : ub.sig;
      quo      = 28'(dividend / {27'b0, divisor});
      rem      = 24'(dividend % {27'b0, divisor});
      div_exp  = ua.exp - ub.exp - $signed({9'b0, ~quo[27]});
      div_norm = quo[27] ? (quo[27:1] | {26'b0, quo[0] | (rem != 24'd0)})
                         : (quo[26:0] | {26'b0, rem != 24'd0});
   end

   logic              rp_sign;
   logic signed [9:0] rp_exp;
   logic [26:0]       rp_sig;
   logic [31:0]       rp_result;
   logic              rp_nx, rp_of, rp_uf;

   always_comb begin
      case (code_q)
         OP_MUL: begin
            rp_sign = ua.sign ^ ub.sign;
            rp_exp  = mul_exp;
            rp_sig  = mul_norm;
         end
         OP_DIV: begin
            rp_sign = ua.sign ^ ub.sign;
            rp_exp  = div_exp;
            rp_sig  = div_norm;
         end
         default: begin
            rp_sign = lg_s;
            rp_exp  = add_exp;
            rp_sig  = add_norm;
         end
      endcase
   end

   maluma_round_pack u_round_pack (
      .sign      (rp_sign),
      .exp       (rp_exp),
      .sig       (rp_sig),
      .single    (single_q),
      .rtz       (rtz_q),
      .result    (rp_result),
      .inexact   (rp_nx),
      .overflow  (rp_of),
      .underflow (rp_uf)
   );

   // ---------------- special cases ----------------
   logic        s_prod;
   logic [31:0] qnan, inf_p, zero_p;

   always_comb begin
      s_prod = ua.sign ^ ub.sign;
      qnan   = pack_special(single_q, 1'b0, SP_QNAN_MAG, HP_QNAN_MAG);
      inf_p  = pack_special(single_q, s_prod, SP_INF_MAG, HP_INF_MAG);
      zero_p = pack_special(single_q, s_prod, 31'd0, 15'd0);
      res_c  = rp_result;
      flg_c  = '0;
      flg_c[FLAG_NX] = rp_nx;
      flg_c[FLAG_OF] = rp_of;
      flg_c[FLAG_UF] = rp_uf;

      if (code_q > OP_DIV) begin
         res_c = qnan;
         flg_c = '0;
         flg_c[FLAG_NV] = 1'b1;
      end else if (ua.nan || ub.nan) begin
         res_c = qnan;
         flg_c = '0;
      end else if (code_q == OP_MUL) begin
         if ((ua.zero && ub.inf) || (ua.inf && ub.zero)) begin
            res_c = qnan;
            flg_c = '0;
            flg_c[FLAG_NV] = 1'b1;
         end else if (ua.inf || ub.inf) begin
            res_c = inf_p;
            flg_c = '0;
         end else if (ua.zero || ub.zero) begin
            res_c = zero_p;
            flg_c = '0;
         end
      end else if (code_q == OP_DIV) begin
         if ((ua.zero && ub.zero) || (ua.inf && ub.inf)) begin
            res_c = qnan;
            flg_c = '0;
            flg_c[FLAG_NV] = 1'b1;
         end else if (ub.inf) begin
            res_c = zero_p;
            flg_c = '0;
         end else if (ua.inf) begin
            res_c = inf_p;
            flg_c = '0;
         end else if (ub.zero) begin
            res_c = inf_p;
            flg_c = '0;
            flg_c[FLAG_DZ] = 1'b1;
         end else if (ua.zero) begin
            res_c = zero_p;
            flg_c = '0;
         end
      end else begin
         if (ua.inf && ub.inf && (ua.sign != sb_eff)) begin
            res_c = qnan;
            flg_c = '0;
            flg_c[FLAG_NV] = 1'b1;
         end else if (ua.inf) begin
            res_c = pack_special(single_q, ua.sign, SP_INF_MAG, HP_INF_MAG);
            flg_c = '0;
         end else if (ub.inf) begin
            res_c = pack_special(single_q, sb_eff, SP_INF_MAG, HP_INF_MAG);
            flg_c = '0;
         end else if (add_zero) begin
            // Only (-0)+(-0) keeps a negative sign; cancellation gives +0.
            res_c = pack_special(single_q, ua.sign & sb_eff, 31'd0, 15'd0);
            flg_c = '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_maluma_alu.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module      : tb_maluma_alu
// Description : Directed self-checking bench for maluma_alu.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
module tb_maluma_alu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] op_a = '0;
   logic [31:0] op_b = '0;
   logic [2:0]  op_code = '0;
   logic        mode_fp = 1'b1;
   logic        round_mode = 1'b0;
   logic [31:0] result;
   logic        valid_out;
   logic [4:0]  flags;

   int checks = 0;
   int errors = 0;

   maluma_alu dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .op_a       (op_a),
      .op_b       (op_b),
      .op_code    (op_code),
      .mode_fp    (mode_fp),
      .round_mode (round_mode),
      .result     (result),
      .valid_out  (valid_out),
      .flags      (flags)
   );

   always #5 clk = ~clk;

   // Issues one operation, scrambles the inputs right after start is taken,
   // and waits (bounded) for valid_out. lat counts edges after the start edge.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic m, input logic rm,
                         output logic [31:0] res, output logic [4:0] flg,
                         output int lat);
      @(negedge clk);
      op_a = a; op_b = b; op_code = op; mode_fp = m; round_mode = rm;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      op_a = ~a; op_b = ~b; op_code = 3'b110; mode_fp = ~m; round_mode = ~rm;
      lat = 0;
      while (!valid_out && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!valid_out) begin
         res = 32'hDEADBEEF;
         flg = 5'h1F;
      end else begin
         res = result;
         flg = flags;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (result !== 32'h0 || flags !== 5'h0 || valid_out !== 1'b0) begin
         errors++;
         $display("FAIL reset: result %h flags %b valid %b, want 0 0 0",
                  result, flags, valid_out);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single_arith();
      logic [31:0] a [5] = '{32'h40000000, 32'h40C00000, 32'hC0A00000, 32'h40A00000, 32'h3F800001};
      logic [31:0] b [5] = '{32'h40400000, 32'h40000000, 32'hC0400000, 32'hC0000000, 32'h33800000};
      logic [2:0]  o [5] = '{3'b000, 3'b011, 3'b010, 3'b010, 3'b000};
      logic [31:0] e [5] = '{32'h40A00000, 32'h40400000, 32'h41700000, 32'hC1200000, 32'h3F800002};
      logic [4:0]  f [5] = '{5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b10000};
      logic [31:0] res;
      logic [4:0]  flg;
      int          lat;
      for (int i = 0; i < 5; i++) begin
         run_op(a[i], b[i], o[i], 1'b1, 1'b0, res, flg, lat);
         checks++;
         if (res !== e[i] || flg !== f[i]) begin
            errors++;
            $display("FAIL single[%0d]: result %h flags %b, want %h %b", i, res, flg, e[i], f[i]);
         end
      end
   endtask

   task automatic test_latency();
      logic [31:0] res;
      logic [4:0]  flg;
      int          lat;
      run_op(32'h40000000, 32'h40400000, 3'b000, 1'b1, 1'b0, res, flg, lat);
      checks++;
      if (lat !== 2 || res !== 32'h40A00000) begin
         errors++;
         $display("FAIL latency: edges %0d result %h, want 2 40a00000", lat, res);
      end
      // valid_out and result hold while idle
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (valid_out !== 1'b1 || result !== 32'h40A00000) begin
         errors++;
         $display("FAIL hold: valid %b result %h, want 1 40a00000", valid_out, result);
      end
   endtask

   task automatic test_half();
      logic [31:0] a [4] = '{32'hABCD4200, 32'h00004500, 32'hFFFF4000, 32'h00004200};
      logic [31:0] b [4] = '{32'h12344500, 32'h55554200, 32'h00004200, 32'h00003800};
      logic [2:0]  o [4] = '{3'b000, 3'b001, 3'b010, 3'b011};
      logic [31:0] e [4] = '{32'h00004800, 32'h00004000, 32'h00004600, 32'h00004600};
      logic [31:0] res;
      logic [4:0]  flg;
      int          lat;
      for (int i = 0; i < 4; i++) begin
         run_op(a[i], b[i], o[i], 1'b0, 1'b0, res, flg, lat);
         checks++;
         if (res !== e[i] || flg !== 5'b00000) begin
            errors++;
            $display("FAIL half[%0d]: result %h flags %b, want %h 00000", i, res, flg, e[i]);
         end
      end
   endtask

   task automatic test_specials();
      logic [31:0] a [6] = '{32'h7FC00000, 32'h40400000, 32'h40A00000, 32'h7F800000, 32'h40000000, 32'h00800000};
      logic [31:0] b [6] = '{32'h40A00000, 32'h7F800000, 32'h7F800000, 32'h7F800000, 32'h40000000, 32'h3F000000};
      logic [2:0]  o [6] = '{3'b000, 3'b001, 3'b011, 3'b001, 3'b101, 3'b010};
      logic [31:0] e [6] = '{32'h7FC00000, 32'hFF800000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'h00000000};
      logic [4:0]  f [6] = '{5'b00000, 5'b00000, 5'b00000, 5'b01000, 5'b01000, 5'b10001};
      logic [31:0] res;
      logic [4:0]  flg;
      int          lat;
      for (int i = 0; i < 6; i++) begin
         run_op(a[i], b[i], o[i], 1'b1, 1'b0, res, flg, lat);
         checks++;
         if (res !== e[i] || flg !== f[i]) begin
            errors++;
            $display("FAIL special[%0d]: result %h flags %b, want %h %b", i, res, flg, e[i], f[i]);
         end
      end
   endtask

   task automatic test_divzero();
      logic [31:0] a [4] = '{32'h40A00000, 32'hC0400000, 32'h00000000, 32'h0000C200};
      logic [31:0] e [4] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h0000FC00};
      logic [4:0]  f [4] = '{5'b00100, 5'b00100, 5'b01000, 5'b00100};
      logic        m [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic [31:0] res;
      logic [4:0]  flg;
      int          lat;
      for (int i = 0; i < 4; i++) begin
         run_op(a[i], 32'h00000000, 3'b011, m[i], 1'b0, res, flg, lat);
         checks++;
         if (res !== e[i] || flg !== f[i]) begin
            errors++;
            $display("FAIL divzero[%0d]: result %h flags %b, want %h %b", i, res, flg, e[i], f[i]);
         end
      end
   endtask

   task automatic test_signed_zero();
      logic [31:0] a [4] = '{32'h00000000, 32'h80000000, 32'h00008000, 32'h40400000};
      logic [31:0] b [4] = '{32'h80000000, 32'h80000000, 32'h00008000, 32'h40400000};
      logic [2:0]  o [4] = '{3'b000, 3'b000, 3'b000, 3'b001};
      logic        m [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic [31:0] e [4] = '{32'h00000000, 32'h80000000, 32'h00008000, 32'h00000000};
      logic [31:0] res;
      logic [4:0]  flg;
      int          lat;
      for (int i = 0; i < 4; i++) begin
         run_op(a[i], b[i], o[i], m[i], 1'b0, res, flg, lat);
         checks++;
         if (res !== e[i] || flg !== 5'b00000) begin
            errors++;
            $display("FAIL signed_zero[%0d]: result %h flags %b, want %h 00000", i, res, flg, e[i]);
         end
      end
   endtask

   task automatic test_rounding();
      logic [31:0] a [3] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h3F800001};
      logic [31:0] b [3] = '{32'h40000000, 32'h40000000, 32'h33800000};
      logic [2:0]  o [3] = '{3'b010, 3'b010, 3'b000};
      logic        r [3] = '{1'b0, 1'b1, 1'b1};
      logic [31:0] e [3] = '{32'h7F800000, 32'h7F7FFFFF, 32'h3F800001};
      logic [4:0]  f [3] = '{5'b10010, 5'b10010, 5'b10000};
      logic [31:0] res;
      logic [4:0]  flg;
      int          lat;
      for (int i = 0; i < 3; i++) begin
         run_op(a[i], b[i], o[i], 1'b1, r[i], res, flg, lat);
         checks++;
         if (res !== e[i] || flg !== f[i]) begin
            errors++;
            $display("FAIL rounding[%0d]: result %h flags %b, want %h %b", i, res, flg, e[i], f[i]);
         end
      end
   endtask

   task automatic test_abort();
      logic [31:0] res;
      logic [4:0]  flg;
      int          lat;
      @(negedge clk);
      op_a = 32'h40000000; op_b = 32'h40400000; op_code = 3'b000;
      mode_fp = 1'b1; round_mode = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (valid_out !== 1'b0 || result !== 32'h0) begin
         errors++;
         $display("FAIL abort_async: valid %b result %h, want 0 00000000", valid_out, result);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (valid_out !== 1'b0 || result !== 32'h0 || flags !== 5'h0) begin
         errors++;
         $display("FAIL abort_after: valid %b result %h flags %b, want 0 00000000 00000",
                  valid_out, result, flags);
      end
      run_op(32'h40C00000, 32'h40000000, 3'b001, 1'b1, 1'b0, res, flg, lat);
      checks++;
      if (res !== 32'h40800000 || flg !== 5'b00000) begin
         errors++;
         $display("FAIL recover: result %h flags %b, want 40800000 00000", res, flg);
      end
   endtask

   initial begin
      test_reset();
      test_single_arith();
      test_latency();
      test_half();
      test_specials();
      test_divzero();
      test_signed_zero();
      test_rounding();
      test_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire
